// File: rtl/dc1_xbit_fill.sv
// dc1_xbit_fill
//   Line-fill assembler and insert arbiter for the L1 data-cache pbit store.
//   Four L2 fill beats (4 pbits each) are assembled into one 16-bit half-line
//   row and buffered in a 2-entry FIFO. The FIFO head is written as a whole-row
//   insert on pbit-store write port 0, which is shared with store-pbit updates.
//
// Handshake: a fill beat transfers on every rising clk edge where
//   fill_valid & fill_ready is high; fill_valid may be asserted regardless of
//   fill_ready and the beat fields must stay stable until the transfer. Stores
//   have no ready: a store presented with st_stall high is not performed and
//   the requester re-presents it on a later cycle.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   fill_valid/addr/odd/beat/pbit fill beat in; fill_ready accept; fill_cancel abort
//   fill_err                      sticky out-of-order beat flag
//   st_*                          store pbit update request; st_stall = not taken
//   write0_*                      pbit store port 0 (store pass-through or insert row)
//   write_ins, write_data         insert strobe (one-hot bank) and row pbits
//   dbg_state_o                   assembler state (1 = COLLECT)
module dc1_xbit_fill #(
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fill_valid,
   input  logic [ADDR_WIDTH+4:0] fill_addr,
   input  logic                  fill_odd,
   input  logic [1:0]            fill_beat,
   input  logic [3:0]            fill_pbit,
   input  logic                  fill_cancel,
   output logic                  fill_ready,
   output logic                  fill_err,
   input  logic                  st_clkEn,
   input  logic                  st_odd,
   input  logic                  st_d128,
   input  logic [ADDR_WIDTH+4:0] st_addrE,
   input  logic [ADDR_WIDTH+4:0] st_addrO,
   input  logic [1:0]            st_pbit,
   output logic                  st_stall,
   output logic                  write0_clkEn,
   output logic                  write0_odd,
   output logic                  write0_d128,
   output logic [ADDR_WIDTH+4:0] write0_addrE,
   output logic [ADDR_WIDTH+4:0] write0_addrO,
   output logic [1:0]            write0_pbit,
   output logic [1:0]            write_ins,
   output logic [15:0]           write_data,
   output logic                  dbg_state_o
);

   localparam int AW = ADDR_WIDTH + 5;             // full address width
   localparam int RW = ADDR_WIDTH + 1;             // row tag = addr[AW-1:4]
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

   typedef struct packed {
      logic [RW-1:0] row;
      logic          odd;
      logic [15:0]   data;
   } entry_t;

   state_t        state_q, state_d;
   logic [15:0]   img_q, img_d;
   logic [RW-1:0] row_q, row_d;
   logic          odd_q, odd_d;
   logic [1:0]    beat_exp_q, beat_exp_d;
   logic          err_q, err_d;
   entry_t        q0_q, q0_d, q1_q, q1_d;          // q0 is the FIFO head
   logic [1:0]    cnt_q, cnt_d;
   logic [CW-1:0] starve_q, starve_d;

   logic          accept, push, pop, head_v;
   entry_t        push_e;
   logic [AW-1:0] st_sel;
   logic [RW-1:0] st_row;
   logic          hit0, hit1, hazard, ins;
   logic          unused_bits;

   // Only the row part of fill/store addresses participates.
   assign unused_bits = ^{fill_addr[3:0], st_sel[3:0]};

   assign fill_ready  = (cnt_q < 2'd2) & ~fill_cancel & ~rst;
   assign accept      = fill_valid & fill_ready;
   assign fill_err    = err_q;
   assign dbg_state_o = (state_q == S_COLLECT);

   // Assembler: next state, shift image and FIFO push.
   always_comb begin
      state_d    = state_q;
      img_d      = img_q;
      row_d      = row_q;
      odd_d      = odd_q;
      beat_exp_d = beat_exp_q;
      err_d      = err_q;
      push       = 1'b0;
      push_e     = '0;
      if (fill_cancel) begin
         // fill_ready is low here, so a same-cycle beat is never taken.
         state_d = S_IDLE;
      end else if (accept) begin
         case (state_q)
            S_IDLE: begin
               if (fill_beat == 2'd0) begin
                  row_d      = fill_addr[AW-1:4];
                  odd_d      = fill_odd;
                  img_d      = {12'h000, fill_pbit};
                  beat_exp_d = 2'd1;
                  state_d    = S_COLLECT;
               end else begin
                  err_d = 1'b1;
               end
            end
            S_COLLECT: begin
               if (fill_beat == beat_exp_q) begin
                  img_d[{fill_beat, 2'b00} +: 4] = fill_pbit;
                  beat_exp_d = beat_exp_q + 2'd1;
                  if (fill_beat == 2'd3) begin
                     push        = 1'b1;
                     push_e.row  = row_q;
                     push_e.odd  = odd_q;
                     push_e.data = {fill_pbit, img_q[11:0]};
                     state_d     = S_IDLE;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Port 0 arbitration. A hazard on any queued entry forces the head out, so
   // a store to a queued row keeps stalling until that row has been inserted.
   assign st_sel = st_odd ? st_addrO : st_addrE;
   assign st_row = st_sel[AW-1:4];
   assign head_v = (cnt_q != 2'd0);
   assign hit0   = head_v && (q0_q.row == st_row) && (q0_q.odd == st_odd);
   assign hit1   = (cnt_q == 2'd2) && (q1_q.row == st_row) && (q1_q.odd == st_odd);
   assign hazard = hit0 | hit1;
   assign ins    = head_v & ~rst &
                   (~st_clkEn | (starve_q == CW'(STARVE_LIMIT)) | hazard);
   assign pop    = ins;

   always_comb begin
      write_ins    = 2'b00;
      write_data   = 16'h0000;
      write0_addrE = st_addrE;
      write0_addrO = st_addrO;
      write0_odd   = st_odd;
      write0_d128  = st_d128;
      write0_pbit  = st_pbit;
      write0_clkEn = st_clkEn & ~rst;
      st_stall     = ~rst & st_clkEn & hazard & ~hit0;
      if (ins) begin
         write_ins    = {q0_q.odd, ~q0_q.odd};
         write_data   = q0_q.data;
         write0_addrE = {q0_q.row, 4'h0};
         write0_addrO = {q0_q.row, 4'h0};
         write0_odd   = q0_q.odd;
         write0_d128  = 1'b0;
         write0_pbit  = 2'b00;
         write0_clkEn = 1'b0;
         st_stall     = st_clkEn;
      end
   end

   // FIFO and starvation counter.
   always_comb begin
      q0_d  = q0_q;
      q1_d  = q1_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
      if (pop) q0_d = q1_q;
      if (push) begin
         if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) q0_d = push_e;
         else                                             q1_d = push_e;
      end
      starve_d = starve_q;
      if (ins || !head_v)                                 starve_d = '0;
      else if (st_clkEn && starve_q != CW'(STARVE_LIMIT)) starve_d = starve_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         img_q      <= '0;
         row_q      <= '0;
         odd_q      <= 1'b0;
         beat_exp_q <= 2'd0;
         err_q      <= 1'b0;
         q0_q       <= '0;
         q1_q       <= '0;
         cnt_q      <= 2'd0;
         starve_q   <= '0;
      end else begin
         state_q    <= state_d;
         img_q      <= img_d;
         row_q      <= row_d;
         odd_q      <= odd_d;
         beat_exp_q <= beat_exp_d;
         err_q      <= err_d;
         q0_q       <= q0_d;
         q1_q       <= q1_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
      end
   end

endmodule

// File: doc/dc1_xbit_fill.md
# dc1_xbit_fill

Line-fill assembler and insert arbiter for the L1 data-cache per-chunk extra-bit (pbit) store. It collects the 16 pbits for a newly filled half-line from four L2 fill beats and buffers completed lines in a 2-entry queue. It issues each line as a whole-row insert (`write_ins`/`write_data`) on write port 0 of the pbit store, sharing that port with store-pbit updates. It arbitrates between the two, with starvation and same-line hazard protection.

## Interface
- `ADDR_WIDTH`, default 5 (6 in the 256K build); row index width of the pbit store.
- `STARVE_LIMIT`, default 8; blocked-insert cycles before the insert forcibly wins the port.

Ports (`clk` and `rst` first):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `fill_valid`  in  1  fill beat present.
- `fill_addr`  in  ADDR_WIDTH+5  line address; bits [3:0] ignored.
- `fill_odd`  in  1  bank of the filled line.
- `fill_beat`  in  2  beat index.
- `fill_pbit`  in  4  pbits for chunks 4·beat..4·beat+3.
- `fill_cancel`  in  1  abort the assembly in progress.
- `fill_ready`  out  1  beat accepted when `fill_valid & fill_ready`.
- `fill_err`  out  1  sticky out-of-order-beat flag; cleared only by `rst`.
- `st_clkEn`, `st_odd`, `st_d128`  in  1 each  store pbit update request.
- `st_addrE`, `st_addrO`  in  ADDR_WIDTH+5 each  store addresses.
- `st_pbit`  in  2  store pbits.
- `st_stall`  out  1  store not accepted this cycle; requester retries.
- `write0_clkEn`, `write0_odd`, `write0_d128`  out  1 each  to pbit store port 0.
- `write0_addrE`, `write0_addrO`  out  ADDR_WIDTH+5 each  to pbit store port 0.
- `write0_pbit`  out  2  to pbit store port 0.
- `write_ins`  out  2  insert strobe, one-hot bank select ({odd, ~odd}).
- `write_data`  out  16  inserted row pbits.

## Operation
- **Assembler FSM** has two states, IDLE and COLLECT. It holds a 16-bit shift image, the latched address and `odd`, and the expected beat counter.
  - IDLE: an accepted beat with index 0 latches `fill_addr`/`fill_odd`, writes bits [3:0], sets expected=1, and moves to COLLECT. An accepted beat with any other index sets `fill_err`, is dropped, and the FSM stays in IDLE.
  - COLLECT: an accepted beat k equal to expected writes bits [4k+3:4k]. Beat 3 pushes {addr, odd, data} to the queue and returns to IDLE.
  - COLLECT, beat k not equal to expected: sets `fill_err`, discards the partial line, and returns to IDLE.
  - `fill_cancel` in any state discards the partial line and returns to IDLE. It wins over a same-cycle beat, which is not accepted. The queue is untouched.
- **`fill_ready`** = (queue count < 2) & ~`fill_cancel` & ~`rst`.
- **Queue**: 2 entries, FIFO. A push and a pop in the same cycle are both allowed; the count is unchanged.
- **Port 0 arbitration** (combinational, same cycle). Issue the insert when the head is valid and any of these hold:
  - `st_clkEn` = 0;
  - the starvation counter equals `STARVE_LIMIT`;
  - a hazard exists: the selected store address (`st_odd` ? `st_addrO` : `st_addrE`) bits [ADDR_WIDTH+4:4] and `st_odd` match any valid queue entry.
- **Insert cycle**:
  - `write_ins` = {head.odd, ~head.odd}; `write_data` = head.data.
  - `write0_addrE` = `write0_addrO` = {head.addr[ADDR_WIDTH+4:4], 4'h0}; `write0_odd` = head.odd.
  - `write0_clkEn` = 0; `write0_d128` = 0; `write0_pbit` = 0.
  - `st_stall` = `st_clkEn`. The head is popped.
- **Non-insert cycle**:
  - `write0_*` pass the `st_*` inputs through.
  - `write_ins` = 0. `st_stall` = 1 only while a hazard holds with the queue empty of a matching head. Otherwise it is 0.
- **Hazard with a matching non-head entry**: the head issues first (forced). The store stalls until the matching entry has drained.
- **Starvation counter**: increments each cycle the head is valid and blocked by `st_clkEn`; saturates at `STARVE_LIMIT`. It clears on every insert issue and whenever the queue is empty.

## Timing
- Beat 3 accepted in cycle N: the entry is visible in the queue at N+1. The earliest `write_ins` is at N+1.
- Worst-case insert latency with a saturated store stream: `STARVE_LIMIT`+1 cycles after the entry becomes head.
- Store path latency is 0 (combinational pass-through); the insert decision is purely combinational from registered state and the `st_*` inputs.
- During and after `rst`:
  - queue empty, FSM IDLE, counter 0, `fill_err` 0;
  - `write_ins`=0, `write0_clkEn`=0, `st_stall`=0;
  - `fill_ready`=0 while `rst` is high and 1 the cycle after.
- Reset mid-assembly or with queued entries discards everything; no insert is issued.
- Single-port guarantee: `write_ins` ≠ 0 and `write0_clkEn`=1 are never both true.

## Test plan
- **In-order fill**: beats 0..3 with `fill_pbit` = 1,2,4,8, `fill_odd`=1, `st_clkEn`=0 -> one cycle after beat 3, `write_ins`=2'b10 and `write_data`=16'h8421.
- **Starvation**: with `STARVE_LIMIT`=8, queue one line and hold `st_clkEn`=1 continuously -> the insert issues on the 9th blocked cycle, with `st_stall`=1 and `write0_clkEn`=0 in that cycle only.
- **Hazard**: queue a line with addr 0x120, odd=0; present a store with `st_addrE`=0x125 and `st_odd`=0 -> insert issued immediately and `st_stall`=1. On retry the next cycle, the store passes through.
- **Backpressure**: complete three lines while holding `st_clkEn`=1 -> `fill_ready`=0 after the second line. The queue drains in FIFO order, and the third line is accepted after the first pop.
- **Cancel and order error**: beats 0,1, then `fill_cancel` together with beat 2 -> beat 2 is not accepted and no insert is issued. A subsequent beat 2 arriving in IDLE sets `fill_err`=1 and produces no insert.
